// File: rtl/enigma_pkg.sv
// Shared rotor definitions: 52-symbol letter ring and ASCII conversion helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package enigma_pkg;

  localparam int RING_SIZE = 52;
  localparam logic [5:0] LAST_IDX = 6'(RING_SIZE - 1);

  localparam logic [7:0] CH_UA = 8'h41; // 'A'
  localparam logic [7:0] CH_UZ = 8'h5A; // 'Z'
  localparam logic [7:0] CH_LA = 8'h61; // 'a'
  localparam logic [7:0] CH_LZ = 8'h7A; // 'z'
  localparam logic [7:0] CH_QM = 8'h3F; // '?', substituted for non-letters

  // One registered result: decoded character plus its error qualifier.
  typedef struct packed {
    logic       err;
    logic [7:0] ch;
  } res_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_UA) && (c <= CH_UZ)) || ((c >= CH_LA) && (c <= CH_LZ));
  endfunction

  // Upper case maps to 0..25, lower case to 26..51; non-letters are don't-care.
  function automatic logic [5:0] char_to_idx(input logic [7:0] c);
    logic [7:0] d;
    if (c <= CH_UZ) d = c - CH_UA;
    else            d = c - CH_LA + 8'd26;
    return d[5:0];
  endfunction

  function automatic logic [7:0] idx_to_char(input logic [5:0] i);
    if (i < 6'd26) return CH_UA + {2'b00, i};
    else           return CH_LA + {2'b00, i} - 8'd26;
  endfunction

endpackage

// File: rtl/rotor_position_counter.sv
// Rotor position register with load/step priority, ring wrap and notch carry.
// Latency: 1 cycle from load/advance to pos; carry_out registered alongside.
// Backpressure: none; stepping never stalls.
module rotor_position_counter
  import enigma_pkg::*;
#(
  parameter int NOTCH    = 51,
  parameter int INIT_POS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [5:0] load_pos,
  input  logic       advance,
  output logic [5:0] pos,
  output logic       carry_out
);

  localparam logic [5:0] NOTCH_P = 6'(NOTCH);
  localparam logic [5:0] INIT_P  = 6'(INIT_POS);

  logic [5:0] pos_nxt;
  logic       carry_nxt;

  // Next position: load beats advance; out-of-range loads leave pos alone.
  always_comb begin
    pos_nxt   = pos;
    carry_nxt = 1'b0;
    if (load_en) begin
      if (load_pos <= LAST_IDX) pos_nxt = load_pos;
    end else if (advance) begin
      pos_nxt   = (pos == LAST_IDX) ? 6'd0 : pos + 6'd1;
      carry_nxt = (pos == NOTCH_P);
    end
  end

  // Position and carry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= INIT_P;
      carry_out <= 1'b0;
    end else begin
      pos       <= pos_nxt;
      carry_out <= carry_nxt;
    end
  end

endmodule

// File: rtl/rotor_inverse_stage.sv
// Return-path rotor: idx = (c - OFFSET - pos) mod 52 on the letter ring, '?' for non-letters.
// Latency: 1 cycle, result registered with out_valid.
// Backpressure: in_ready = !out_valid || out_ready; result held while stalled.
module rotor_inverse_stage
  import enigma_pkg::*;
#(
  parameter int OFFSET   = 27,
  parameter int NOTCH    = 51,
  parameter int INIT_POS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       step,
  input  logic       carry_in,
  input  logic       load_en,
  input  logic [5:0] load_pos,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_err,
  output logic [5:0] pos,
  output logic       carry_out
);

  localparam logic [7:0] OFFSET_B = 8'(OFFSET);

  logic       accept;
  logic [7:0] sum;
  logic [7:0] t;
  res_t       dec;
  res_t       res_q;

  rotor_position_counter #(
    .NOTCH    (NOTCH),
    .INIT_POS (INIT_POS)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_pos  (load_pos),
    .advance   (step | carry_in),
    .pos       (pos),
    .carry_out (carry_out)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode against the pre-edge position; the +104 bias keeps the 8-bit sum non-negative.
  always_comb begin
    sum = {2'b00, char_to_idx(in_char)} + 8'd104 - OFFSET_B - {2'b00, pos};
    t   = sum % 8'd52;
    dec = '0;
    if (is_letter(in_char)) begin
      dec.ch  = idx_to_char(t[5:0]);
      dec.err = 1'b0;
    end else begin
      dec.ch  = CH_QM;
      dec.err = 1'b1;
    end
  end

  // Output register: load on accept, drop valid on drain, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_char = res_q.ch;
  assign out_err  = res_q.err;

endmodule

// File: tb/tb_rotor_inverse_stage.sv
// Self-checking bench for rotor_inverse_stage: directed cases then randomized traffic.
// Reference model works on an alphabet string with plain integer modular arithmetic.
// Stimulus driven on the falling edge, outputs sampled 1ns after the rising edge.
module tb_rotor_inverse_stage;

  localparam int OFFSET   = 27;
  localparam int NOTCH    = 51;
  localparam int INIT_POS = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       step;
  logic       carry_in;
  logic       load_en;
  logic [5:0] load_pos;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_err;
  logic [5:0] pos;
  logic       carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";

  // Reference state
  int         m_pos;
  bit         m_carry;
  bit         m_vld;
  logic [7:0] m_char;
  bit         m_err;

  rotor_inverse_stage #(
    .OFFSET   (OFFSET),
    .NOTCH    (NOTCH),
    .INIT_POS (INIT_POS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .step      (step),
    .carry_in  (carry_in),
    .load_en   (load_en),
    .load_pos  (load_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_err   (out_err),
    .pos       (pos),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inverse rotor from the alphabet: find the letter's ring index, subtract offset and position.
  function automatic logic [8:0] ref_decode(input logic [7:0] c, input int p);
    for (int i = 0; i < 52; i++) begin
      if (8'(alpha[i]) == c) begin
        int t;
        t = ((i - OFFSET - p) % 52 + 52) % 52;
        return {1'b0, 8'(alpha[t])};
      end
    end
    return {1'b1, 8'h3F};
  endfunction

  task automatic model_reset();
    m_pos   = INIT_POS;
    m_carry = 1'b0;
    m_vld   = 1'b0;
    m_char  = 8'h00;
    m_err   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    check({tag, ".pos"},       32'(pos),       32'(m_pos));
    check({tag, ".carry_out"}, 32'(carry_out), 32'(m_carry));
    if (m_vld) begin
      check({tag, ".out_char"}, 32'(out_char), 32'(m_char));
      check({tag, ".out_err"},  32'(out_err),  32'(m_err));
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic cycle(input bit iv, input logic [7:0] ch, input bit st, input bit ci,
                       input bit le, input logic [5:0] lp, input bit ordy, input string tag);
    bit         exp_rdy;
    logic [8:0] d;
    @(negedge clk);
    in_valid  = iv;
    in_char   = ch;
    step      = st;
    carry_in  = ci;
    load_en   = le;
    load_pos  = lp;
    out_ready = ordy;
    #1;
    exp_rdy = !m_vld || ordy;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (iv && exp_rdy) begin
      d      = ref_decode(ch, m_pos);
      m_vld  = 1'b1;
      m_char = d[7:0];
      m_err  = d[8];
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    m_carry = 1'b0;
    if (le) begin
      if (int'(lp) <= 51) m_pos = int'(lp);
    end else if (st || ci) begin
      m_carry = (m_pos == NOTCH);
      m_pos   = (m_pos + 1) % 52;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input bit ordy, input string tag);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd0, ordy, tag);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_char = 8'h00; step = 1'b0; carry_in = 1'b0;
    load_en = 1'b0; load_pos = 6'd0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_char",  32'(out_char),  32'h00);
    check("reset.out_err",   32'(out_err),   32'd0);
    check("reset.pos",       32'(pos),       32'(INIT_POS));
    check("reset.carry_out", 32'(carry_out), 32'd0);
    check("reset.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;

    // 'b' at pos 0 decodes to 'A'
    cycle(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, "b_pos0");
    check("b_pos0.const", 32'(out_char), 32'h41);
    idle(1'b1, "drain0");

    // load 5 then 'B' decodes to 'V'
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, "load5");
    check("load5.pos", 32'(pos), 32'd5);
    cycle(1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, "B_pos5");
    check("B_pos5.const", 32'(out_char), 32'h56);
    check("B_pos5.step_after", 32'(pos), 32'd6);

    // wrap 51 -> 0 through the notch
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd51, 1'b1, "load51");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, "wrap");
    check("wrap.pos_const", 32'(pos), 32'd0);
    check("wrap.carry_const", 32'(carry_out), 32'd1);
    idle(1'b1, "wrap_after");
    check("wrap_after.carry_const", 32'(carry_out), 32'd0);

    // step and carry_in together advance once
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd10, 1'b1, "load10");
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, "dual_adv");
    check("dual_adv.pos_const", 32'(pos), 32'd11);

    // non-letter
    cycle(1'b1, 8'h35, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, "digit");
    check("digit.char_const", 32'(out_char), 32'h3F);
    check("digit.err_const",  32'(out_err),  32'd1);

    // stall with two chars offered, stepping continues underneath
    cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "stall_first");
    cycle(1'b1, 8'h63, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, "stall_hold1");
    cycle(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, "stall_hold2");
    cycle(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, "stall_release");
    idle(1'b1, "stall_drain");
    check("stall_drain.vld_const", 32'(out_valid), 32'd0);

    // out-of-range load leaves pos unchanged
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 6'd60, 1'b1, "load60");
    check("load60.pos_const", 32'(pos), 32'd12);

    // asynchronous reset with a pending result at pos 30
    cycle(1'b1, 8'h7A, 1'b0, 1'b0, 1'b1, 6'd30, 1'b0, "pre_rst");
    in_valid = 1'b0; load_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.pos",       32'(pos),       32'(INIT_POS));
    check("arst.carry_out", 32'(carry_out), 32'd0);
    check("arst.out_char",  32'(out_char),  32'h00);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] c;
      if ($urandom_range(0, 1) == 0) c = 8'(alpha[$urandom_range(0, 51)]);
      else                           c = 8'($urandom_range(0, 255));
      cycle($urandom_range(0, 9) < 7, c,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, 6'($urandom_range(0, 63)),
            $urandom_range(0, 9) < 6, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
